inst_page_cache: RTL and testbench

INST_PAGE_CACHE -- requirements
Module: inst_page_cache

---
 rtl/inst_page_cache_pkg.sv | 18 +
 rtl/inst_page_ram.sv | 41 ++++
 rtl/inst_page_cache.sv | 192 +++++++++++++++++++
 tb/tb_inst_page_cache.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_page_cache_pkg.sv
// Shared definitions for the instruction page cache.
//   - AXI4 read-channel encodings used on the master port
//   - fill FSM state encoding
package inst_page_cache_pkg;

    localparam logic [2:0] ARSIZE_32    = 3'b010;   // 4-byte beats
    localparam logic [1:0] BURST_INCR   = 2'b01;
    localparam logic [3:0] CACHE_NORMAL = 4'b0011;  // normal, non-cacheable, bufferable
    localparam logic [1:0] RESP_OKAY    = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,   // serving hits, launching fills on miss
        ST_AR   = 2'd1,   // read address outstanding
        ST_R    = 2'd2,   // draining one burst into the page RAM
        ST_ERR  = 2'd3    // fill failed, waiting for fence.i or a new page
    } state_e;

endpackage

// File: rtl/inst_page_ram.sv
// Page storage: 2^AW x DW simple dual-port RAM.
//   clk_i              clock
//   rst_ni             async active-low reset of the read register only
//   we_i/waddr_i/wdata_i   write port
//   re_i/raddr_i       registered read port; rdata_o holds while re_i=0
//   rdata_o            read data (one cycle after re_i)
// The array itself is never reset.
module inst_page_ram #(
    parameter int unsigned AW = 10,
    parameter int unsigned DW = 32
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [2**AW];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/inst_page_cache.sv
// Single-page instruction cache with an AXI4 read-only master.
//   CLK, RSTN            clock, async active-low reset
//   STALL                hold INST/INST_VALID, no RAM read
//   INVALIDATE           fence.i pulse, drops the resident page
//   PC_VALID, PC         fetch request
//   MEM_WAIT             fetch cannot complete this cycle (combinational)
//   INST_VALID, INST     fetched word, one cycle after a hit
//   FETCH_ERR            last fill returned a non-OKAY response
//   M_AXI_AR*/R*         AXI4 read address / data channels
// A miss refills the whole page as PAGE/(BURST_LEN*4) back-to-back bursts.
module inst_page_cache
    import inst_page_cache_pkg::*;
#(
    parameter int unsigned PAGE_BITS    = 12,
    parameter int unsigned BURST_LEN    = 32,
    parameter logic [31:0] RESET_ARADDR = 32'h2000_0000
) (
    input  logic        CLK,
    input  logic        RSTN,
    input  logic        STALL,
    input  logic        INVALIDATE,
    input  logic        PC_VALID,
    input  logic [31:0] PC,
    output logic        MEM_WAIT,
    output logic        INST_VALID,
    output logic [31:0] INST,
    output logic        FETCH_ERR,
    output logic [31:0] M_AXI_ARADDR,
    output logic [7:0]  M_AXI_ARLEN,
    output logic [2:0]  M_AXI_ARSIZE,
    output logic [1:0]  M_AXI_ARBURST,
    output logic        M_AXI_ARVALID,
    input  logic        M_AXI_ARREADY,
    output logic [3:0]  M_AXI_ARID,
    output logic        M_AXI_ARLOCK,
    output logic [3:0]  M_AXI_ARCACHE,
    output logic [2:0]  M_AXI_ARPROT,
    output logic [3:0]  M_AXI_ARQOS,
    output logic        M_AXI_ARUSER,
    input  logic [31:0] M_AXI_RDATA,
    input  logic [1:0]  M_AXI_RRESP,
    input  logic        M_AXI_RLAST,
    input  logic        M_AXI_RVALID,
    output logic        M_AXI_RREADY
);

    localparam int unsigned WA = PAGE_BITS - 2;
    localparam int unsigned TW = 32 - PAGE_BITS;
    localparam logic [31:0] BURST_BYTES = 32'(BURST_LEN * 4);

    state_e        state_q;
    logic          tag_valid_q;
    logic [TW-1:0] tag_q;
    logic [TW-1:0] fill_page_q;
    logic [WA-1:0] wcnt_q;
    logic [WA-1:0] wcnt_d;
    logic          err_q;
    logic          inv_pend_q;
    logic          arvalid_q;
    logic [31:0]   araddr_q;
    logic          inst_valid_q;
    logic          fetch_err_q;

    logic [TW-1:0] pc_page;
    logic          hit;
    logic          beat_err;
    logic          page_done;
    logic          ram_we;
    logic          ram_re;
    logic          unused_pc;

    assign pc_page   = PC[31:PAGE_BITS];
    assign hit       = PC_VALID && tag_valid_q && (pc_page == tag_q) && (state_q == ST_IDLE);
    assign beat_err  = (M_AXI_RRESP != RESP_OKAY);
    assign wcnt_d    = wcnt_q + WA'(1);
    // The beat being written is the last word of the page.
    assign page_done = &wcnt_q;
    assign ram_we    = (state_q == ST_R) && M_AXI_RVALID;
    assign ram_re    = hit && !STALL;
    assign unused_pc = ^PC[1:0];

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q      <= ST_IDLE;
            tag_valid_q  <= 1'b0;
            tag_q        <= '1;
            fill_page_q  <= '0;
            wcnt_q       <= '0;
            err_q        <= 1'b0;
            inv_pend_q   <= 1'b0;
            arvalid_q    <= 1'b0;
            araddr_q     <= RESET_ARADDR;
            inst_valid_q <= 1'b0;
            fetch_err_q  <= 1'b0;
        end else begin
            if (!STALL) begin
                inst_valid_q <= hit;
            end
            unique case (state_q)
                ST_IDLE: begin
                    if (INVALIDATE) begin
                        tag_valid_q <= 1'b0;
                    end
                    if (PC_VALID && !hit) begin
                        fill_page_q <= pc_page;
                        araddr_q    <= {pc_page, {PAGE_BITS{1'b0}}};
                        tag_valid_q <= 1'b0;
                        arvalid_q   <= 1'b1;
                        wcnt_q      <= '0;
                        err_q       <= 1'b0;
                        inv_pend_q  <= 1'b0;
                        state_q     <= ST_AR;
                    end
                end
                ST_AR: begin
                    if (INVALIDATE) begin
                        inv_pend_q <= 1'b1;
                    end
                    if (M_AXI_ARREADY) begin
                        arvalid_q <= 1'b0;
                        state_q   <= ST_R;
                    end
                end
                ST_R: begin
                    if (INVALIDATE) begin
                        inv_pend_q <= 1'b1;
                    end
                    if (M_AXI_RVALID) begin
                        wcnt_q <= wcnt_d;
                        if (beat_err) begin
                            err_q <= 1'b1;
                        end
                        if (M_AXI_RLAST) begin
                            if (err_q || beat_err) begin
                                fetch_err_q  <= 1'b1;
                                inst_valid_q <= 1'b0;
                                state_q      <= ST_ERR;
                            end else if (page_done) begin
                                // A fence.i seen mid-fill leaves the fresh page unusable.
                                tag_q       <= fill_page_q;
                                tag_valid_q <= !(inv_pend_q || INVALIDATE);
                                state_q     <= ST_IDLE;
                            end else begin
                                araddr_q  <= araddr_q + BURST_BYTES;
                                arvalid_q <= 1'b1;
                                state_q   <= ST_AR;
                            end
                        end
                    end
                end
                ST_ERR: begin
                    inst_valid_q <= 1'b0;
                    if (INVALIDATE || (PC_VALID && (pc_page != fill_page_q))) begin
                        fetch_err_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    inst_page_ram #(
        .AW (WA),
        .DW (32)
    ) u_ram (
        .clk_i   (CLK),
        .rst_ni  (RSTN),
        .we_i    (ram_we),
        .waddr_i (wcnt_q),
        .wdata_i (M_AXI_RDATA),
        .re_i    (ram_re),
        .raddr_i (PC[PAGE_BITS-1:2]),
        .rdata_o (INST)
    );

    assign MEM_WAIT      = PC_VALID && !hit && (state_q != ST_ERR);
    assign INST_VALID    = inst_valid_q;
    assign FETCH_ERR     = fetch_err_q;
    assign M_AXI_ARADDR  = araddr_q;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_ARLEN   = 8'(BURST_LEN - 1);
    assign M_AXI_ARSIZE  = ARSIZE_32;
    assign M_AXI_ARBURST = BURST_INCR;
    assign M_AXI_ARCACHE = CACHE_NORMAL;
    assign M_AXI_ARID    = '0;
    assign M_AXI_ARLOCK  = 1'b0;
    assign M_AXI_ARPROT  = '0;
    assign M_AXI_ARQOS   = '0;
    assign M_AXI_ARUSER  = 1'b0;
    assign M_AXI_RREADY  = 1'b1;

endmodule

// File: tb/tb_inst_page_cache.sv
// Directed bench for inst_page_cache with a behavioural AXI4 read slave.
module tb_inst_page_cache;

    localparam int BL = 32;

    logic        CLK, RSTN, STALL, INVALIDATE, PC_VALID;
    logic [31:0] PC;
    logic        MEM_WAIT, INST_VALID, FETCH_ERR;
    logic [31:0] INST;
    logic [31:0] M_AXI_ARADDR;
    logic [7:0]  M_AXI_ARLEN;
    logic [2:0]  M_AXI_ARSIZE;
    logic [1:0]  M_AXI_ARBURST;
    logic        M_AXI_ARVALID, M_AXI_ARREADY;
    logic [3:0]  M_AXI_ARID, M_AXI_ARCACHE, M_AXI_ARQOS;
    logic        M_AXI_ARLOCK, M_AXI_ARUSER;
    logic [2:0]  M_AXI_ARPROT;
    logic [31:0] M_AXI_RDATA;
    logic [1:0]  M_AXI_RRESP;
    logic        M_AXI_RLAST, M_AXI_RVALID, M_AXI_RREADY;

    inst_page_cache #(
        .PAGE_BITS    (12),
        .BURST_LEN    (BL),
        .RESET_ARADDR (32'h2000_0000)
    ) dut (
        .CLK           (CLK),
        .RSTN          (RSTN),
        .STALL         (STALL),
        .INVALIDATE    (INVALIDATE),
        .PC_VALID      (PC_VALID),
        .PC            (PC),
        .MEM_WAIT      (MEM_WAIT),
        .INST_VALID    (INST_VALID),
        .INST          (INST),
        .FETCH_ERR     (FETCH_ERR),
        .M_AXI_ARADDR  (M_AXI_ARADDR),
        .M_AXI_ARLEN   (M_AXI_ARLEN),
        .M_AXI_ARSIZE  (M_AXI_ARSIZE),
        .M_AXI_ARBURST (M_AXI_ARBURST),
        .M_AXI_ARVALID (M_AXI_ARVALID),
        .M_AXI_ARREADY (M_AXI_ARREADY),
        .M_AXI_ARID    (M_AXI_ARID),
        .M_AXI_ARLOCK  (M_AXI_ARLOCK),
        .M_AXI_ARCACHE (M_AXI_ARCACHE),
        .M_AXI_ARPROT  (M_AXI_ARPROT),
        .M_AXI_ARQOS   (M_AXI_ARQOS),
        .M_AXI_ARUSER  (M_AXI_ARUSER),
        .M_AXI_RDATA   (M_AXI_RDATA),
        .M_AXI_RRESP   (M_AXI_RRESP),
        .M_AXI_RLAST   (M_AXI_RLAST),
        .M_AXI_RVALID  (M_AXI_RVALID),
        .M_AXI_RREADY  (M_AXI_RREADY)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h0F1E_2D3C;
    endfunction

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // ---------------- AXI read slave ----------------
    int          ar_count    = 0;
    int          beats_left  = 0;
    int          beat_idx    = 0;
    int          total_beats = 0;
    int          ar_wait     = 0;
    int          wait_cnt    = 0;
    int          ar_hold_err = 0;
    bit          inj_en      = 1'b0;
    int          inj_ar      = 0;
    int          inj_beat    = 0;
    logic [31:0] burst_addr  = '0;
    logic [31:0] held_addr   = '0;
    logic [31:0] ar_log [0:511];

    initial begin
        M_AXI_ARREADY = 1'b1;
        M_AXI_RVALID  = 1'b0;
        M_AXI_RLAST   = 1'b0;
        M_AXI_RDATA   = '0;
        M_AXI_RRESP   = 2'b00;
        forever begin
            @(negedge CLK);
            if (beats_left > 0) begin
                M_AXI_RVALID = 1'b1;
                M_AXI_RDATA  = mem_word(burst_addr + 32'(4 * beat_idx));
                M_AXI_RRESP  = (inj_en && ar_count == inj_ar && beat_idx == inj_beat) ? 2'b10 : 2'b00;
                M_AXI_RLAST  = (beats_left == 1);
                beat_idx++;
                beats_left--;
                total_beats++;
            end else begin
                M_AXI_RVALID = 1'b0;
                M_AXI_RLAST  = 1'b0;
                M_AXI_RRESP  = 2'b00;
                if (M_AXI_ARVALID) begin
                    if (wait_cnt < ar_wait) begin
                        if (wait_cnt == 0) held_addr = M_AXI_ARADDR;
                        else if (M_AXI_ARADDR !== held_addr) ar_hold_err++;
                        M_AXI_ARREADY = 1'b0;
                        wait_cnt++;
                    end else begin
                        if (ar_wait > 0 && M_AXI_ARADDR !== held_addr) ar_hold_err++;
                        M_AXI_ARREADY = 1'b1;
                        wait_cnt = 0;
                        ar_log[ar_count] = M_AXI_ARADDR;
                        ar_count++;
                        burst_addr = M_AXI_ARADDR;
                        beats_left = BL;
                        beat_idx   = 0;
                    end
                end else begin
                    M_AXI_ARREADY = 1'b1;
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic wait_fill(input string tag, input int max_cyc, output int inst_changes);
        logic [31:0] i0;
        logic        v0;
        bit          done;
        i0 = INST;
        v0 = INST_VALID;
        inst_changes = 0;
        done = 1'b0;
        for (int c = 0; c < max_cyc && !done; c++) begin
            @(negedge CLK);
            #1;
            if (INST !== i0 || INST_VALID !== v0) inst_changes++;
            if (!MEM_WAIT) done = 1'b1;
        end
        chk({tag, "_done"}, 32'(done), 32'd1);
    endtask

    task automatic hit1(input string tag, input logic [31:0] addr);
        @(negedge CLK);
        PC = addr;
        PC_VALID = 1'b1;
        #1 chk({tag, "_mw"}, 32'(MEM_WAIT), 32'd0);
        @(negedge CLK);
        #1;
        chk({tag, "_inst"}, INST, mem_word(addr));
        chk({tag, "_iv"}, 32'(INST_VALID), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- directed sequence ----------------
    int          a;
    int          tb0;
    int          chg;
    int          bad;
    logic [31:0] prev;
    logic [31:0] held_i;

    initial begin
        RSTN = 1'b0; STALL = 1'b0; INVALIDATE = 1'b0; PC_VALID = 1'b0; PC = '0;
        repeat (3) @(negedge CLK);
        #1;
        chk("rst_arvalid", 32'(M_AXI_ARVALID), 32'd0);
        chk("rst_araddr",  M_AXI_ARADDR, 32'h2000_0000);
        chk("rst_iv",      32'(INST_VALID), 32'd0);
        chk("rst_inst",    INST, 32'd0);
        chk("rst_ferr",    32'(FETCH_ERR), 32'd0);
        chk("rst_mw",      32'(MEM_WAIT), 32'd0);
        chk("arlen",       32'(M_AXI_ARLEN), 32'd31);
        chk("arsize",      32'(M_AXI_ARSIZE), 32'd2);
        chk("arburst",     32'(M_AXI_ARBURST), 32'd1);
        chk("arcache",     32'(M_AXI_ARCACHE), 32'd3);
        chk("arid",        32'({M_AXI_ARID, M_AXI_ARLOCK, M_AXI_ARPROT, M_AXI_ARQOS, M_AXI_ARUSER}), 32'd0);
        chk("rready",      32'(M_AXI_RREADY), 32'd1);
        @(negedge CLK);
        RSTN = 1'b1;

        // Cold fetch
        @(negedge CLK);
        PC = 32'h2000_0000; PC_VALID = 1'b1; a = ar_count;
        #1 chk("cold_mw0", 32'(MEM_WAIT), 32'd1);
        @(negedge CLK);
        #1;
        chk("cold_iv0",    32'(INST_VALID), 32'd0);
        chk("cold_arv",    32'(M_AXI_ARVALID), 32'd1);
        chk("cold_araddr0", M_AXI_ARADDR, 32'h2000_0000);
        wait_fill("cold", 5000, chg);
        chk("cold_ar_n", 32'(ar_count - a), 32'd32);
        for (int i = 0; i < 32; i++)
            chk("cold_ar_addr", ar_log[a + i], 32'h2000_0000 + 32'(i * 32'h80));
        @(negedge CLK);
        #1;
        chk("cold_inst", INST, mem_word(32'h2000_0000));
        chk("cold_iv",   32'(INST_VALID), 32'd1);

        // Hit streaming, one new PC per cycle
        a = ar_count;
        prev = 32'h2000_0000;
        for (int i = 1; i <= 9; i++) begin
            if (i > 1) begin
                @(negedge CLK);
                #1;
                chk("stream_inst", INST, mem_word(prev));
                chk("stream_iv",   32'(INST_VALID), 32'd1);
            end
            prev = (i == 9) ? 32'h2000_0FFC : 32'h2000_0000 + 32'(4 * i);
            PC = prev;
            #1 chk("stream_mw", 32'(MEM_WAIT), 32'd0);
        end
        @(negedge CLK);
        #1 chk("stream_last", INST, mem_word(32'h2000_0FFC));
        chk("stream_no_ar", 32'(ar_count - a), 32'd0);

        // STALL holds output and blocks the RAM read
        STALL = 1'b1; PC = 32'h2000_0040;
        @(negedge CLK);
        #1;
        chk("stall_inst", INST, mem_word(32'h2000_0FFC));
        chk("stall_iv",   32'(INST_VALID), 32'd1);
        STALL = 1'b0;
        @(negedge CLK);
        #1 chk("unstall_inst", INST, mem_word(32'h2000_0040));

        // Page cross while stalled
        STALL = 1'b1; PC = 32'h2000_1000; a = ar_count; held_i = INST;
        #1 chk("cross_mw0", 32'(MEM_WAIT), 32'd1);
        wait_fill("cross", 5000, chg);
        chk("cross_hold", 32'(chg), 32'd0);
        chk("cross_inst_held", INST, held_i);
        chk("cross_ar_n", 32'(ar_count - a), 32'd32);
        chk("cross_ar0",  ar_log[a], 32'h2000_1000);
        STALL = 1'b0;
        @(negedge CLK);
        #1 chk("cross_inst", INST, mem_word(32'h2000_1000));
        hit1("cross_hit", 32'h2000_1A5C);

        // SLVERR on beat 5 of the third burst
        @(negedge CLK);
        a = ar_count; tb0 = total_beats;
        inj_en = 1'b1; inj_ar = a + 3; inj_beat = 5;
        PC = 32'h2000_3000;
        bad = 1;
        for (int c = 0; c < 3000 && bad != 0; c++) begin
            @(negedge CLK);
            #1;
            if (FETCH_ERR) bad = 0;
        end
        chk("err_seen",   32'(bad), 32'd0);
        chk("err_ar_n",   32'(ar_count - a), 32'd3);
        chk("err_drain",  32'(total_beats - tb0), 32'd96);
        chk("err_iv",     32'(INST_VALID), 32'd0);
        chk("err_mw",     32'(MEM_WAIT), 32'd0);
        inj_en = 1'b0;
        bad = 0;
        PC = 32'h2000_3040;
        for (int c = 0; c < 20; c++) begin
            @(negedge CLK);
            #1;
            if (!FETCH_ERR || M_AXI_ARVALID || INST_VALID) bad++;
        end
        chk("err_sticky", 32'(bad), 32'd0);
        chk("err_no_ar",  32'(ar_count - a), 32'd3);
        PC = 32'h2000_2000;
        @(negedge CLK);
        #1;
        chk("err_clear", 32'(FETCH_ERR), 32'd0);
        chk("err_mw1",   32'(MEM_WAIT), 32'd1);
        a = ar_count;
        wait_fill("refill2", 5000, chg);
        chk("refill2_ar0", ar_log[a], 32'h2000_2000);
        chk("refill2_ar_n", 32'(ar_count - a), 32'd32);
        @(negedge CLK);
        #1 chk("refill2_inst", INST, mem_word(32'h2000_2000));

        // INVALIDATE mid-fill, with ARREADY backpressure
        @(negedge CLK);
        ar_wait = 2; a = ar_count; PC = 32'h2000_5000;
        for (int c = 0; c < 2000 && (ar_count - a) < 5; c++) @(negedge CLK);
        #1 INVALIDATE = 1'b1;
        @(negedge CLK);
        INVALIDATE = 1'b0;
        wait_fill("inv", 8000, chg);
        chk("inv_ar_n",    32'(ar_count - a), 32'd64);
        chk("inv_ar_last", ar_log[a + 31], 32'h2000_5F80);
        chk("inv_ar_re",   ar_log[a + 32], 32'h2000_5000);
        chk("ar_hold",     32'(ar_hold_err), 32'd0);
        ar_wait = 0;
        @(negedge CLK);
        #1 chk("inv_inst", INST, mem_word(32'h2000_5000));
        hit1("inv_hit", 32'h2000_5FFC);

        // INVALIDATE in IDLE drops the page
        @(negedge CLK);
        PC_VALID = 1'b0; INVALIDATE = 1'b1;
        @(negedge CLK);
        INVALIDATE = 1'b0; PC_VALID = 1'b1; PC = 32'h2000_5010; a = ar_count;
        #1 chk("idle_inv_mw", 32'(MEM_WAIT), 32'd1);

        // Reset in the middle of the second burst of that refill
        for (int c = 0; c < 2000 && !((ar_count - a) >= 2 && beats_left == 20); c++) @(negedge CLK);
        #1;
        RSTN = 1'b0; PC_VALID = 1'b0;
        #1;
        chk("mrst_arvalid", 32'(M_AXI_ARVALID), 32'd0);
        chk("mrst_araddr",  M_AXI_ARADDR, 32'h2000_0000);
        chk("mrst_inst",    INST, 32'd0);
        repeat (2) @(negedge CLK);
        RSTN = 1'b1;
        a = ar_count; bad = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge CLK);
            #1;
            if (M_AXI_ARVALID || MEM_WAIT || INST_VALID) bad++;
        end
        chk("stray_quiet", 32'(bad), 32'd0);
        chk("stray_no_ar", 32'(ar_count - a), 32'd0);
        PC = 32'h2000_0000; PC_VALID = 1'b1;
        #1 chk("post_rst_mw", 32'(MEM_WAIT), 32'd1);
        wait_fill("post_rst", 5000, chg);
        chk("post_rst_ar_n", 32'(ar_count - a), 32'd32);
        chk("post_rst_ar0",  ar_log[a], 32'h2000_0000);
        @(negedge CLK);
        #1 chk("post_rst_inst", INST, mem_word(32'h2000_0000));
        hit1("post_rst_h1", 32'h2000_0084);
        hit1("post_rst_h2", 32'h2000_0FFC);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
